mmio_uart_ctrl: RTL and testbench

//   Memory-mapped I/O controller in the memory/writeback stage of the three-stage core. Decodes
//   CPU load/store requests at 0x8000_00xx and sequences the on-chip UART through it.

---
 rtl/mmio_uart_ctrl_if.sv | 25 ++
 rtl/mmio_uart_ctrl.sv | 137 +++++++++++++
 tb/tb_mmio_uart_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_ctrl_if.sv
// CPU load/store bus into the MMIO UART controller.
// The CPU side is the master; the controller is the slave that returns registered load data.
interface mmio_uart_ctrl_if;
    logic        req_en;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;

    modport master (
        output req_en,
        output req_we,
        output req_addr,
        output req_wdata,
        input  rdata
    );

    modport slave (
        input  req_en,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller for the on-chip UART (RX FIFO and TX holding register).
// It also provides the cycle and retired-instruction counters that software reads for CPI.
module mmio_uart_ctrl #(
    parameter int          RX_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mmio_uart_ctrl_if.slave        bus,
    input  logic                   inst_retire,
    input  logic [7:0]             uart_rx_data,
    input  logic                   uart_rx_valid,
    output logic                   uart_rx_ready,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_valid,
    input  logic                   uart_tx_ready
);

    localparam int          PTR_W   = $clog2(RX_DEPTH);
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [23:0] BASE_HI = MMIO_BASE[31:8];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rx_count;
    logic [7:0]       rx_mem [RX_DEPTH];

    logic        hit;
    logic        is_load;
    logic        is_store;
    logic [7:0]  offset;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_nonempty;
    logic        tx_write;
    logic        tx_done;
    logic        cnt_clear;
    logic        ovf;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] load_data;
    logic        unused_wdata;

    assign unused_wdata  = ^bus.req_wdata[31:8];

    assign offset        = bus.req_addr[7:0];
    assign hit           = bus.req_en && (bus.req_addr[31:8] == BASE_HI);
    assign is_load       = hit && (bus.req_we == 4'b0000);
    assign is_store      = hit && (bus.req_we != 4'b0000);

    assign rx_nonempty   = (rx_count != '0);
    assign uart_rx_ready = (rx_count != CNT_W'(RX_DEPTH));
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = is_load && (offset == 8'h04) && rx_nonempty;

    assign tx_write      = is_store && (offset == 8'h08) && bus.req_we[0];
    assign tx_done       = uart_tx_valid && uart_tx_ready;
    assign cnt_clear     = is_store && (offset == 8'h18);

    // Load data is built from pre-edge state, so a head read sees the old head even on a push.
    always_comb begin
        load_data = 32'h0;
        case (offset)
            8'h00:   load_data = {29'b0, ovf, rx_nonempty, ~uart_tx_valid};
            8'h04:   load_data = rx_nonempty ? {24'b0, rx_mem[rd_ptr]} : 32'h0;
            8'h10:   load_data = cycle_cnt;
            8'h14:   load_data = inst_cnt;
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= 32'h0;
        end else if (is_load) begin
            bus.rdata <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= uart_rx_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; the count tracks full vs empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_W'(1);
                2'b01:   rx_count <= rx_count - CNT_W'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // A write that lands on the handshake edge replaces the departing byte instead of overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_data  <= 8'h0;
            uart_tx_valid <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            if (tx_write && (!uart_tx_valid || tx_done)) begin
                uart_tx_data  <= bus.req_wdata[7:0];
                uart_tx_valid <= 1'b1;
            end else if (tx_done) begin
                uart_tx_valid <= 1'b0;
            end
            if (cnt_clear) begin
                ovf <= 1'b0;
            end else if (tx_write && uart_tx_valid && !uart_tx_ready) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else if (cnt_clear) begin
            cycle_cnt <= 32'h0;
            inst_cnt  <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed self-checking bench for mmio_uart_ctrl: RX FIFO, TX holding register, counters, reset.
module tb_mmio_uart_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inst_retire;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int checks = 0;
    int errors = 0;

    mmio_uart_ctrl_if bus_if ();

    mmio_uart_ctrl #(.RX_DEPTH(8), .MMIO_BASE(32'h8000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if),
        .inst_retire   (inst_retire),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus helpers: called at a negedge, hold the request across one posedge, return at the next negedge.
    task automatic bus_load(input logic [31:0] addr);
        bus_if.req_en    = 1'b1;
        bus_if.req_we    = 4'b0000;
        bus_if.req_addr  = addr;
        @(negedge clk);
        bus_if.req_en    = 1'b0;
    endtask

    task automatic bus_store(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        bus_if.req_en    = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = data;
        @(negedge clk);
        bus_if.req_en    = 1'b0;
        bus_if.req_we    = 4'b0000;
    endtask

    task automatic push_byte(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.req_en = 1'b1; bus_if.req_we = 4'b0001;
        bus_if.req_addr = 32'h8000_0008; bus_if.req_wdata = 32'h0000_00AA;
        #12;
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected %h", bus_if.rdata, 32'h0); end
        checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready: got %b expected 1", uart_rx_ready); end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", uart_tx_data); end
        bus_if.req_en = 1'b0; bus_if.req_we = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rx_fifo();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
        for (int i = 0; i < 3; i++) begin
            bus_load(32'h8000_0004);
            checks++; if (bus_if.rdata !== {24'h0, exp_b[i]}) begin errors++; $display("[TB] FAIL rx_read%0d: got %h expected %h", i, bus_if.rdata, {24'h0, exp_b[i]}); end
        end
        bus_load(32'h8000_0004);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rx_read_empty: got %h expected %h", bus_if.rdata, 32'h0); end
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h1) begin errors++; $display("[TB] FAIL rx_status_empty: got %h expected %h", bus_if.rdata, 32'h1); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", uart_rx_ready); end
        push_byte(8'h99);
        bus_load(32'h8000_0004);
        checks++; if (bus_if.rdata !== 32'h10) begin errors++; $display("[TB] FAIL full_pop: got %h expected %h", bus_if.rdata, 32'h10); end
        checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL pop_ready: got %b expected 1", uart_rx_ready); end
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h18;
        bus_load(32'h8000_0004);
        uart_rx_valid = 1'b0;
        checks++; if (bus_if.rdata !== 32'h11) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected %h", bus_if.rdata, 32'h11); end
        push_byte(8'h19);
        checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_count: got ready %b expected 0", uart_rx_ready); end
        for (int i = 0; i < 8; i++) begin
            bus_load(32'h8000_0004);
            checks++; if (bus_if.rdata !== {24'h0, 8'h12 + 8'(i)}) begin errors++; $display("[TB] FAIL wrap_order%0d: got %h expected %h", i, bus_if.rdata, {24'h0, 8'h12 + 8'(i)}); end
        end
        bus_load(32'h8000_0004);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL wrap_empty: got %h expected %h", bus_if.rdata, 32'h0); end
    endtask

    task automatic test_tx();
        uart_tx_ready = 1'b0;
        bus_store(32'h8000_0008, 4'b0010, 32'h0000_00AB);
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL tx_we_byte1: got %b expected 0", uart_tx_valid); end
        bus_store(32'h8000_0008, 4'b0001, 32'h0000_0055);
        checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL tx_load_valid: got %b expected 1", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("[TB] FAIL tx_load_data: got %h expected 55", uart_tx_data); end
        bus_store(32'h8000_0008, 4'b0001, 32'h0000_0066);
        checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("[TB] FAIL tx_drop_data: got %h expected 55", uart_tx_data); end
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h4) begin errors++; $display("[TB] FAIL tx_ovf_status: got %h expected %h", bus_if.rdata, 32'h4); end
        bus_store(32'h8000_0018, 4'b0001, 32'h0);
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL ovf_clear_status: got %h expected %h", bus_if.rdata, 32'h0); end
        uart_tx_ready = 1'b1;
        bus_store(32'h8000_0008, 4'b0001, 32'h0000_0088);
        uart_tx_ready = 1'b0;
        checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL tx_replace_valid: got %b expected 1", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h88) begin errors++; $display("[TB] FAIL tx_replace_data: got %h expected 88", uart_tx_data); end
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL tx_replace_no_ovf: got %h expected %h", bus_if.rdata, 32'h0); end
        uart_tx_ready = 1'b1;
        @(negedge clk);
        uart_tx_ready = 1'b0;
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL tx_handshake: got %b expected 0", uart_tx_valid); end
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h1) begin errors++; $display("[TB] FAIL tx_free_status: got %h expected %h", bus_if.rdata, 32'h1); end
    endtask

    task automatic test_counters();
        inst_retire = 1'b1;
        bus_store(32'h8000_0018, 4'b1111, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = ((i % 5) < 2);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        bus_load(32'h8000_0010);
        checks++; if (bus_if.rdata !== 32'd100) begin errors++; $display("[TB] FAIL cycle_count: got %0d expected 100", bus_if.rdata); end
        bus_load(32'h8000_0014);
        checks++; if (bus_if.rdata !== 32'd40) begin errors++; $display("[TB] FAIL inst_count: got %0d expected 40", bus_if.rdata); end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        bus_load(32'h8000_0010);
        checks++; if (bus_if.rdata !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL cycle_preload: got %h expected %h", bus_if.rdata, 32'hFFFF_FFFF); end
        bus_load(32'h8000_0010);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL cycle_wrap: got %h expected %h", bus_if.rdata, 32'h0); end
    endtask

    task automatic test_clear_wins();
        inst_retire = 1'b1;
        bus_store(32'h8000_0018, 4'b0100, 32'h0);
        inst_retire = 1'b0;
        bus_load(32'h8000_0014);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL clear_wins_inst: got %h expected %h", bus_if.rdata, 32'h0); end
        bus_load(32'h8000_0010);
        checks++; if (bus_if.rdata !== 32'h1) begin errors++; $display("[TB] FAIL clear_cycle: got %h expected %h", bus_if.rdata, 32'h1); end
        bus_load(32'h4000_0010);
        checks++; if (bus_if.rdata !== 32'h1) begin errors++; $display("[TB] FAIL miss_holds: got %h expected %h", bus_if.rdata, 32'h1); end
        bus_load(32'h8000_0020);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected %h", bus_if.rdata, 32'h0); end
    endtask

    task automatic test_reset_midrun();
        push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
        uart_tx_ready = 1'b0;
        bus_store(32'h8000_0008, 4'b0001, 32'h0000_005A);
        bus_load(32'h8000_0010);
        checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrun_tx_pending: got %b expected 1", uart_tx_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrun_rdata: got %h expected %h", bus_if.rdata, 32'h0); end
        checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrun_tx_valid: got %b expected 0", uart_tx_valid); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("[TB] FAIL midrun_tx_data: got %h expected 00", uart_tx_data); end
        checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrun_rx_ready: got %b expected 1", uart_rx_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_load(32'h8000_0000);
        checks++; if (bus_if.rdata !== 32'h1) begin errors++; $display("[TB] FAIL midrun_status: got %h expected %h", bus_if.rdata, 32'h1); end
        bus_load(32'h8000_0004);
        checks++; if (bus_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL midrun_fifo_flushed: got %h expected %h", bus_if.rdata, 32'h0); end
    endtask

    initial begin
        bus_if.req_en    = 1'b0;
        bus_if.req_we    = 4'b0000;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;
        inst_retire      = 1'b0;
        uart_rx_data     = 8'h0;
        uart_rx_valid    = 1'b0;
        uart_tx_ready    = 1'b0;
        test_reset();
        test_rx_fifo();
        test_full_wrap();
        test_tx();
        test_counters();
        test_clear_wins();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
